ps2_scan_rx: RTL and testbench

Receives PS/2 keyboard frames on the raw `ps2_clk`/`ps2_data` pins and checks each one. It strips the `F0` (break) and `E0` (extended) prefix bytes and presents one resolved 8-bit scan code per key event, with a single-cycle strobe. It sits directly upstream of the scan-code-to-ASCII converter, whose `key_code` input it drives. It runs entirely in the system clock domain.

---
 rtl/ps2_scan_rx.sv | 161 ++++++++++++++++
 tb/tb_ps2_scan_rx.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_rx.sv
// rtl/ps2_scan_rx.sv - PS/2 keyboard frame receiver with E0/F0 prefix stripping
module ps2_scan_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       key_break,
  output logic       key_ext,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_f, dat_f, clk_f_d;
  logic [FW-1:0] clk_cnt, dat_cnt;
  logic          fall_tick;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [WW-1:0] wdog;
  logic          ext_pend, brk_pend;
  logic          frame_good;

  // Two-flop synchronizers; lines idle high so reset to 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Glitch filters: a new level must persist FILTER_LEN cycles before it is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_f   <= 1'b1;
      dat_f   <= 1'b1;
      clk_cnt <= '0;
      dat_cnt <= '0;
      clk_f_d <= 1'b1;
    end else begin
      clk_f_d <= clk_f;
      if (clk_s2 == clk_f) begin
        clk_cnt <= '0;
      end else if (clk_cnt == FW'(FILTER_LEN - 1)) begin
        clk_f   <= ~clk_f;
        clk_cnt <= '0;
      end else begin
        clk_cnt <= clk_cnt + 1'b1;
      end
      if (dat_s2 == dat_f) begin
        dat_cnt <= '0;
      end else if (dat_cnt == FW'(FILTER_LEN - 1)) begin
        dat_f   <= ~dat_f;
        dat_cnt <= '0;
      end else begin
        dat_cnt <= dat_cnt + 1'b1;
      end
    end
  end

  assign fall_tick  = clk_f_d & ~clk_f;
  // Odd parity over data plus parity bit, and a high stop bit
  assign frame_good = dat_f & (^shreg ^ par_bit);

  // Frame FSM, watchdog and prefix layer; strobes land the cycle after the deciding tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      wdog      <= '0;
      ext_pend  <= 1'b0;
      brk_pend  <= 1'b0;
      key_code  <= 8'h00;
      key_valid <= 1'b0;
      key_break <= 1'b0;
      key_ext   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      if (state == IDLE) begin
        wdog <= '0;
        if (fall_tick) begin
          if (!dat_f) begin
            state   <= DATA;
            bit_cnt <= '0;
          end else begin
            // Missing start bit: treat as a framing error
            frame_err <= 1'b1;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
          end
        end
      end else if (fall_tick) begin
        wdog <= '0;
        case (state)
          DATA: begin
            shreg <= {dat_f, shreg[7:1]};
            if (bit_cnt == 3'd7) state <= PARITY;
            else bit_cnt <= bit_cnt + 1'b1;
          end
          PARITY: begin
            par_bit <= dat_f;
            state   <= STOP;
          end
          default: begin
            state <= IDLE;
            if (frame_good) begin
              if (shreg == 8'hE0) begin
                ext_pend <= 1'b1;
              end else if (shreg == 8'hF0) begin
                brk_pend <= 1'b1;
              end else begin
                key_code  <= shreg;
                key_break <= brk_pend;
                key_ext   <= ext_pend;
                key_valid <= 1'b1;
                ext_pend  <= 1'b0;
                brk_pend  <= 1'b0;
              end
            end else begin
              frame_err <= 1'b1;
              ext_pend  <= 1'b0;
              brk_pend  <= 1'b0;
            end
          end
        endcase
      end else if (wdog == WW'(TIMEOUT)) begin
        // Stalled frame: abandon the partial byte and any pending prefix
        frame_err <= 1'b1;
        ext_pend  <= 1'b0;
        brk_pend  <= 1'b0;
        state     <= IDLE;
        wdog      <= '0;
      end else begin
        wdog <= wdog + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_rx.sv
// tb/tb_ps2_scan_rx.sv - directed self-checking bench for ps2_scan_rx
module tb_ps2_scan_rx;

  localparam int FILTER_LEN = 4;
  localparam int TIMEOUT    = 300;
  localparam int HALF       = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key_code;
  logic       key_valid, key_break, key_ext, frame_err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_err = 0;
  int n_both = 0;
  int err_cyc = 0;
  int last_fall_cyc = 0;

  ps2_scan_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_code(key_code), .key_valid(key_valid), .key_break(key_break),
    .key_ext(key_ext), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor sampled away from the active edge
  always @(negedge clk) begin
    if (key_valid) n_valid <= n_valid + 1;
    if (frame_err) begin
      n_err   <= n_err + 1;
      err_cyc <= cyc;
    end
    if (key_valid && frame_err) n_both <= n_both + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive the first n wire bits, LSB first, optionally with 1-cycle clock glitches
  task automatic send_bits(input logic [10:0] bits, input int n, input bit glitch);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      if (glitch) begin
        wait_cyc(HALF / 2);
        ps2_clk = 1'b0;
        wait_cyc(1);
        ps2_clk = 1'b1;
        wait_cyc(HALF - HALF / 2 - 1);
      end else begin
        wait_cyc(HALF);
      end
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      if (glitch) begin
        wait_cyc(HALF / 2);
        ps2_clk = 1'b1;
        wait_cyc(1);
        ps2_clk = 1'b0;
        wait_cyc(HALF - HALF / 2 - 1);
      end else begin
        wait_cyc(HALF);
      end
      ps2_clk = 1'b1;
    end
    wait_cyc(HALF);
    ps2_data = 1'b1;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par, input bit stop);
    logic par;
    par = (~^b) ^ bad_par;
    return {stop, par, b, 1'b0};
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit stop, input bit glitch);
    send_bits(mk_frame(b, bad_par, stop), 11, glitch);
    wait_cyc(20);
  endtask

  int v0, e0;
  bit got_err;
  int lat;

  initial begin
    wait_cyc(5);
    check("rst_code",  {24'd0, key_code}, 32'h00);
    check("rst_valid", {31'd0, key_valid}, 0);
    check("rst_break", {31'd0, key_break}, 0);
    check("rst_ext",   {31'd0, key_ext}, 0);
    check("rst_err",   {31'd0, frame_err}, 0);
    rst_n = 1'b1;
    wait_cyc(20);

    // Plain make code
    v0 = n_valid; e0 = n_err;
    send_byte(8'h1C, 0, 1, 0);
    check("make_valid_cnt", n_valid - v0, 1);
    check("make_err_cnt",   n_err - e0, 0);
    check("make_code",  {24'd0, key_code}, 32'h1C);
    check("make_break", {31'd0, key_break}, 0);
    check("make_ext",   {31'd0, key_ext}, 0);

    // Break prefix
    v0 = n_valid;
    send_byte(8'hF0, 0, 1, 0);
    send_byte(8'h1C, 0, 1, 0);
    check("brk_valid_cnt", n_valid - v0, 1);
    check("brk_code",  {24'd0, key_code}, 32'h1C);
    check("brk_break", {31'd0, key_break}, 1);
    send_byte(8'h1C, 0, 1, 0);
    check("brk_clear", {31'd0, key_break}, 0);

    // Extended release
    v0 = n_valid;
    send_byte(8'hE0, 0, 1, 0);
    send_byte(8'hF0, 0, 1, 0);
    send_byte(8'h75, 0, 1, 0);
    check("ext_valid_cnt", n_valid - v0, 1);
    check("ext_code",  {24'd0, key_code}, 32'h75);
    check("ext_break", {31'd0, key_break}, 1);
    check("ext_ext",   {31'd0, key_ext}, 1);

    // Parity and stop errors
    v0 = n_valid; e0 = n_err;
    send_byte(8'h1C, 1, 1, 0);
    check("par_err_cnt",   n_err - e0, 1);
    check("par_valid_cnt", n_valid - v0, 0);
    check("par_code", {24'd0, key_code}, 32'h75);
    v0 = n_valid; e0 = n_err;
    send_byte(8'h1C, 0, 0, 0);
    check("stop_err_cnt",   n_err - e0, 1);
    check("stop_valid_cnt", n_valid - v0, 0);
    check("stop_code", {24'd0, key_code}, 32'h75);
    send_byte(8'h16, 0, 1, 0);
    check("recover_code", {24'd0, key_code}, 32'h16);

    // Timeout after start + 4 data bits
    e0 = n_err;
    send_bits(mk_frame(8'h45, 0, 1), 5, 0);
    got_err = 0;
    for (int i = 0; i < TIMEOUT + 100 && !got_err; i++) begin
      wait_cyc(1);
      if (n_err != e0) got_err = 1;
    end
    check("to_seen", {31'd0, got_err}, 1);
    lat = err_cyc - last_fall_cyc;
    check("to_latency_window", {31'd0, (lat >= TIMEOUT && lat <= TIMEOUT + 15)}, 1);
    wait_cyc(10);
    v0 = n_valid;
    send_byte(8'h45, 0, 1, 0);
    check("to_next_cnt",  n_valid - v0, 1);
    check("to_next_code", {24'd0, key_code}, 32'h45);

    // Timeout drops a pending break prefix
    send_byte(8'hF0, 0, 1, 0);
    send_bits(mk_frame(8'h45, 0, 1), 5, 0);
    wait_cyc(TIMEOUT + 40);
    send_byte(8'h45, 0, 1, 0);
    check("to_brk_code",  {24'd0, key_code}, 32'h45);
    check("to_brk_break", {31'd0, key_break}, 0);

    // Glitchy clock
    v0 = n_valid; e0 = n_err;
    send_byte(8'h2B, 0, 1, 1);
    check("glitch_valid_cnt", n_valid - v0, 1);
    check("glitch_err_cnt",   n_err - e0, 0);
    check("glitch_code", {24'd0, key_code}, 32'h2B);

    // Reset mid-frame
    v0 = n_valid;
    send_bits(mk_frame(8'h4D, 0, 1), 3, 0);
    rst_n = 1'b0;
    wait_cyc(3);
    check("mrst_code",  {24'd0, key_code}, 32'h00);
    check("mrst_break", {31'd0, key_break}, 0);
    check("mrst_ext",   {31'd0, key_ext}, 0);
    check("mrst_err",   {31'd0, frame_err}, 0);
    rst_n = 1'b1;
    wait_cyc(20);
    check("mrst_no_strobe", n_valid - v0, 0);
    send_byte(8'h4D, 0, 1, 0);
    check("mrst_next_cnt",  n_valid - v0, 1);
    check("mrst_next_code", {24'd0, key_code}, 32'h4D);

    check("never_both", n_both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
